fifo_wr_arbiter: RTL and testbench

//   Round-robin write-port arbiter that shares one fifo_sync write port among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 94 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-facing signal bundle for fifo_wr_arbiter.
// The arbiter uses the slave view; the producers and FIFO side use the master view.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_cs;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic [IdW-1:0]                grant_id;
   logic                          busy;

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// holding each grant for up to BURST_MAX words and stalling on fifo_full.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_MAX  = 4
) (
   input logic             clk,
   input logic             rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = $clog2(BURST_MAX) + 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [IdW-1:0]  LAST_ID  = IdW'(NUM_REQ - 1);
   localparam logic [CntW-1:0] CNT_LAST = CntW'(BURST_MAX - 1);

   logic [0:0]         r_state;
   logic [IdW-1:0]     r_owner;
   logic [CntW-1:0]    r_burst_cnt;

   logic               w_grant;
   logic               w_any;
   logic               w_xfer;
   logic               w_release;
   logic [IdW-1:0]     w_pick;
   logic [NUM_REQ-1:0] w_ready;

   // Scan downward so the nearest requester after the owner wins; owner itself is last.
   always_comb begin
      w_pick = r_owner;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         if (bus.req_valid[(32'(r_owner) + k) % NUM_REQ]) begin
            w_pick = IdW'((32'(r_owner) + k) % NUM_REQ);
         end
      end
   end

   assign w_any   = |bus.req_valid;
   // Gating with rst keeps the reset cycle free of FIFO writes.
   assign w_grant = (r_state == ST_GRANT) && !rst;

   always_comb begin
      w_ready = '0;
      if (w_grant && !bus.fifo_full) begin
         w_ready[r_owner] = 1'b1;
      end
   end

   assign w_xfer    = bus.req_valid[r_owner] & w_ready[r_owner];
   assign w_release = (w_xfer && (r_burst_cnt == CNT_LAST)) || !bus.req_valid[r_owner];

   assign bus.req_ready    = w_ready;
   assign bus.fifo_wr_en   = w_xfer;
   assign bus.fifo_cs      = w_xfer;
   assign bus.fifo_data_in = w_grant ? bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH]
                                     : '0;
   assign bus.grant_id     = rst ? LAST_ID : r_owner;
   assign bus.busy         = w_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= LAST_ID;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state     <= ST_GRANT;
                  r_owner     <= w_pick;
                  r_burst_cnt <= '0;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  if (w_any) begin
                     r_owner     <= w_pick;
                     r_burst_cnt <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_xfer) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a queue-based
// scoreboard fed by a behavioural model and drained by a write monitor.
module tb_fifo_wr_arbiter;
   localparam int unsigned NR = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned BM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   seq[NR];

   // Model: is some producer holding the port, who, and how many words it has moved.
   bit   m_busy   = 1'b0;
   int   m_owner  = NR - 1;
   int   m_served = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // First valid producer walking the ring forward from the one after 'from'.
   function automatic int next_owner(input logic [NR-1:0] v, input int from);
      for (int k = 1; k <= int'(NR); k++) begin
         if (v[(from + k) % NR]) return (from + k) % NR;
      end
      return from;
   endfunction

   task automatic cycle(input logic [NR-1:0] v, input logic f, input logic r);
      logic [NR-1:0] exp_ready;
      bit            exp_busy;
      bit            exp_wr;
      bit            done;
      int            exp_gid;
      @(negedge clk);
      rst           = r;
      bus.fifo_full = f;
      bus.req_valid = v;
      for (int i = 0; i < int'(NR); i++) begin
         bus.req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
      end
      #1;
      exp_busy  = !r && m_busy;
      exp_gid   = r ? NR - 1 : m_owner;
      exp_ready = '0;
      exp_wr    = 1'b0;
      if (exp_busy && !f) exp_ready[m_owner] = 1'b1;
      if (exp_busy && !f && v[m_owner]) begin
         exp_wr = 1'b1;
         sb.push_back('{id: m_owner, data: {8'(m_owner), 24'(seq[m_owner])}});
         seq[m_owner]++;
      end
      check("busy", 64'(bus.busy), 64'(exp_busy));
      check("grant_id", 64'(bus.grant_id), 64'(exp_gid));
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (!exp_busy) check("data_idle", 64'(bus.fifo_data_in), 64'd0);

      if (r) begin
         m_busy   = 1'b0;
         m_owner  = NR - 1;
         m_served = 0;
      end else if (!m_busy) begin
         if (v != '0) begin
            m_busy   = 1'b1;
            m_owner  = next_owner(v, m_owner);
            m_served = 0;
         end
      end else begin
         done = (exp_wr && (m_served + 1 == int'(BM))) || !v[m_owner];
         if (done) begin
            if (v != '0) begin
               m_owner  = next_owner(v, m_owner);
               m_served = 0;
            end else begin
               m_busy = 1'b0;
            end
         end else if (exp_wr) begin
            m_served++;
         end
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         check("cs_vs_wr_en", 64'(bus.fifo_cs), 64'(bus.fifo_wr_en));
         if (bus.fifo_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got %0h want none", bus.fifo_data_in);
            end else begin
               e = sb.pop_front();
               check("write_data", 64'(bus.fifo_data_in), 64'(e.data));
            end
         end else if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_write: got none want %0h", e.data);
         end
      end
   end

   initial begin
      for (int i = 0; i < int'(NR); i++) seq[i] = 0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;

      // T1: reset with everyone asking.
      repeat (2) cycle(4'hF, 1'b0, 1'b1);
      cycle(4'h0, 1'b0, 1'b0);

      // T2: lone requester 1, six words across two bursts.
      repeat (7) cycle(4'b0010, 1'b0, 1'b0);
      cycle(4'h0, 1'b0, 1'b0);

      // T3: everyone continuously valid.
      cycle(4'h0, 1'b0, 1'b1);
      repeat (22) cycle(4'hF, 1'b0, 1'b0);

      // T4: stall req2 mid-burst.
      cycle(4'h0, 1'b0, 1'b1);
      repeat (3) cycle(4'b0100, 1'b0, 1'b0);
      repeat (5) cycle(4'b0101, 1'b1, 1'b0);
      repeat (8) cycle(4'b0101, 1'b0, 1'b0);

      // T5: req0 drops valid after one word.
      cycle(4'h0, 1'b0, 1'b1);
      repeat (2) cycle(4'b1001, 1'b0, 1'b0);
      repeat (4) cycle(4'b1000, 1'b0, 1'b0);

      // T6: reset in the middle of a req1 burst.
      cycle(4'h0, 1'b0, 1'b1);
      repeat (3) cycle(4'b0010, 1'b0, 1'b0);
      cycle(4'b0011, 1'b0, 1'b1);
      repeat (6) cycle(4'b0011, 1'b0, 1'b0);

      // Random traffic with occasional full and rare resets.
      for (int n = 0; n < 2000; n++) begin
         cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 199) == 0));
      end

      cycle(4'h0, 1'b0, 1'b0);
      @(negedge clk);
      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
